// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: computes every output node of one dense layer on a
// single shared multiply-accumulate datapath. For each node it streams N_IN
// weights and one bias from an external weight memory, then spends one drain
// cycle applying ReLU and saturating 8-bit requantisation to the result.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; act_in is captured on the accepted edge
//   S_RUN  | issuing addresses, accumulating returned data, draining
module layer_mac_sequencer #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 32,
  parameter int W     = 24,
  parameter int AW    = 9,
  parameter int IW    = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [N_IN*W-1:0] act_in_i,
  output logic              w_rd_o,
  output logic [AW-1:0]     w_addr_o,
  input  logic [W-1:0]      w_data_i,
  output logic              busy_o,
  output logic              out_valid_o,
  output logic [IW-1:0]     out_idx_o,
  output logic [W-1:0]      out_data_o,
  output logic              done_o
);

  // Phase counter covers the N_IN+1 issue cycles plus the drain cycle.
  localparam int KW = $clog2(N_IN + 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IW-1:0]   n_q, n_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            w_rd_q, w_rd_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            done_q, done_d;
  logic            load_act;
  logic [W-1:0]    act_q [N_IN];
  logic [W-1:0]    act_k;
  logic [W-1:0]    term;
  logic [W-1:0]    quant;

  // Select the activation paired with the weight currently returning, and
  // form the accumulate term (the bias slot adds w_data unscaled).
  always_comb begin
    act_k = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (k_q == KW'(i)) act_k = act_q[i];
    end
    // Low W bits of the product are identical for signed and unsigned operands.
    term = (k_q == KW'(N_IN)) ? w_data_i : W'(act_k * w_data_i);
  end

  // ReLU then saturate; acc == 8192 deliberately falls through to acc[12:5] = 0
  // to stay bit-exact with the existing per-node implementation.
  always_comb begin
    quant = '0;
    if (acc_q[W-1]) quant = '0;
    else if (acc_q > W'(8192)) quant = W'(255);
    else quant = {{(W-8){1'b0}}, acc_q[12:5]};
  end

  // Next-state and output decode for the pass sequencer.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    acc_d       = acc_q;
    w_rd_d      = w_rd_q;
    w_addr_d    = w_addr_q;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    load_act    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load_act = 1'b1;
          state_d  = S_RUN;
          k_d      = '0;
          n_d      = '0;
          w_rd_d   = 1'b1;
          w_addr_d = '0;
        end
      end
      S_RUN: begin
        // Data for the address presented this cycle is valid at this edge.
        if (w_rd_q) acc_d = ((k_q == '0) ? '0 : acc_q) + term;
        if (k_q == KW'(N_IN + 1)) begin
          out_valid_d = 1'b1;
          out_idx_d   = n_q;
          out_data_d  = quant;
          if (n_q == IW'(N_OUT - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d      = n_q + IW'(1);
            k_d      = '0;
            w_rd_d   = 1'b1;
            // Addresses are contiguous: node n's bias is followed by node n+1's k=0.
            w_addr_d = w_addr_q + AW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
          if (k_q == KW'(N_IN)) w_rd_d = 1'b0;
          else w_addr_d = w_addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      w_rd_q      <= 1'b0;
      w_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      w_rd_q      <= w_rd_d;
      w_addr_q    <= w_addr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Activation bank, loaded only when a pass is accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_IN; i++) act_q[i] <= '0;
    end else if (load_act) begin
      for (int i = 0; i < N_IN; i++) act_q[i] <= act_in_i[i*W +: W];
    end
  end

  assign busy_o      = (state_q == S_RUN);
  assign w_rd_o      = w_rd_q;
  assign w_addr_o    = w_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign out_data_o  = out_data_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: weight memory model, output scoreboard and
// one task per scenario.
module tb_layer_mac_sequencer;

  localparam int N_IN  = 15;
  localparam int N_OUT = 32;
  localparam int W     = 24;
  localparam int AW    = 9;
  localparam int IW    = 5;
  localparam int P     = N_IN + 2;
  localparam int NW    = N_OUT * (N_IN + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start = 1'b0;
  logic [N_IN*W-1:0] act_in = '0;
  logic              w_rd;
  logic [AW-1:0]     w_addr;
  logic [W-1:0]      w_data = '0;
  logic              busy;
  logic              out_valid;
  logic [IW-1:0]     out_idx;
  logic [W-1:0]      out_data;
  logic              done;

  logic [W-1:0] mem [NW];
  logic [W-1:0] act_arr [N_IN];

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int e0    = 0;
  int n_out = 0;

  layer_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .AW(AW), .IW(IW)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .start_i     (start),
    .act_in_i    (act_in),
    .w_rd_o      (w_rd),
    .w_addr_o    (w_addr),
    .w_data_i    (w_data),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_idx_o   (out_idx),
    .out_data_o  (out_data),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: data for the address presented after an edge is valid at the
  // following edge; garbage is driven whenever no read is outstanding.
  always @(posedge clk) begin
    #1;
    if (w_rd) w_data = mem[w_addr];
    else w_data = W'($urandom);
  end

  // Scoreboard: every out_valid pops one expected result.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid) begin
        n_out++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out_valid: got idx=%0d data=%0d, none expected", out_idx, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_cmp++;
          if (out_idx !== IW'(e.idx) || out_data !== e.data) begin
            n_err++;
            $display("FAIL out_result: got idx=%0d data=%0d, want idx=%0d data=%0d",
                     out_idx, out_data, e.idx, e.data);
          end
          n_cmp++;
          if ((cyc - e0) !== P * (e.idx + 1)) begin
            n_err++;
            $display("FAIL out_timing idx=%0d: got edge E0+%0d, want E0+%0d", e.idx, cyc - e0, P * (e.idx + 1));
          end
          n_cmp++;
          if (done !== (e.idx == N_OUT - 1)) begin
            n_err++;
            $display("FAIL done_with_valid idx=%0d: got done=%b, want %b", e.idx, done, e.idx == N_OUT - 1);
          end
        end
      end else if (done) begin
        n_cmp++; n_err++;
        $display("FAIL done_without_valid: got done=1, want 0");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  task automatic pack_acts();
    for (int i = 0; i < N_IN; i++) act_in[i*W +: W] = act_arr[i];
  endtask

  task automatic fill_mem(input logic [W-1:0] wt, input logic [W-1:0] bias);
    for (int n = 0; n < N_OUT; n++) begin
      for (int k = 0; k < N_IN; k++) mem[n*(N_IN+1)+k] = wt;
      mem[n*(N_IN+1)+N_IN] = bias;
    end
  endtask

  task automatic push_all(input logic [W-1:0] val);
    for (int n = 0; n < N_OUT; n++) sb.push_back('{idx: n, data: val});
  endtask

  function automatic logic [W-1:0] model(input int n);
    longint       s;
    logic [W-1:0] a;
    s = 0;
    for (int k = 0; k < N_IN; k++)
      s += longint'(act_arr[k]) * longint'(mem[n*(N_IN+1)+k]);
    s += longint'(mem[n*(N_IN+1)+N_IN]);
    a = s[W-1:0];
    if (a[W-1]) return '0;
    if (a > 24'd8192) return 24'd255;
    return {16'd0, a[12:5]};
  endfunction

  // Launch a pass; e0 becomes the edge number at which start was accepted.
  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_idle(output bit timed_out);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 1500) begin
      @(negedge clk);
      t++;
    end
    timed_out = (t >= 1500);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b, want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b, want 0", done); end
    n_cmp++; if (w_rd !== 1'b0)      begin n_err++; $display("FAIL reset_w_rd: got %b, want 0", w_rd); end
    n_cmp++; if (w_addr !== '0)      begin n_err++; $display("FAIL reset_w_addr: got %0d, want 0", w_addr); end
    n_cmp++; if (out_idx !== '0)     begin n_err++; $display("FAIL reset_out_idx: got %0d, want 0", out_idx); end
    n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL reset_out_data: got %0d, want 0", out_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < N_IN; i++) act_arr[i] = 24'd32;
    pack_acts();
    fill_mem(24'd1, 24'd0);
    push_all(24'd15);
    n_out = 0;
    start_pass();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %b, want 1", busy); end
    repeat (P*N_OUT - 1) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_before_end: got %b, want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_fall: got %b, want 0 at E0+%0d", busy, P*N_OUT); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done_edge: got %b, want 1 at E0+%0d", done, P*N_OUT); end
    wait_idle(to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL basic_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++; if (n_out != 32) begin n_err++; $display("FAIL basic_count: got %0d outputs, want 32", n_out); end
  endtask

  task automatic test_negative();
    bit to;
    for (int i = 0; i < N_IN; i++) act_arr[i] = 24'd32;
    pack_acts();
    fill_mem(24'hFFFFFF, 24'd0);
    mem[3*(N_IN+1)+N_IN] = 24'd480;
    push_all(24'd0);
    n_out = 0;
    start_pass();
    wait_idle(to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL neg_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++; if (n_out != 32) begin n_err++; $display("FAIL neg_count: got %0d outputs, want 32", n_out); end
  endtask

  task automatic test_thresholds();
    bit to;
    logic [W-1:0] bias [4];
    logic [W-1:0] want [4];
    bias = '{24'd8191, 24'd8192, 24'd8193, 24'd160};
    want = '{24'd255, 24'd0, 24'd255, 24'd5};
    for (int i = 0; i < N_IN; i++) act_arr[i] = W'($urandom);
    pack_acts();
    fill_mem(24'd0, 24'd0);
    for (int n = 0; n < N_OUT; n++) begin
      mem[n*(N_IN+1)+N_IN] = bias[n % 4];
      sb.push_back('{idx: n, data: want[n % 4]});
    end
    n_out = 0;
    start_pass();
    wait_idle(to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL thresh_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++; if (n_out != 32) begin n_err++; $display("FAIL thresh_count: got %0d outputs, want 32", n_out); end
  endtask

  task automatic test_wrap_addr();
    bit to;
    int ph, nn, exp_addr;
    bit exp_rd;
    act_arr[0] = 24'h800000;
    for (int i = 1; i < N_IN; i++) act_arr[i] = W'($urandom);
    pack_acts();
    fill_mem(24'd0, 24'd7);
    for (int n = 0; n < N_OUT; n++) mem[n*(N_IN+1)] = 24'd2;
    push_all(24'd0);
    n_out = 0;
    start_pass();
    for (int j = 0; j < P*N_OUT; j++) begin
      ph = j % P;
      nn = j / P;
      exp_rd = (ph <= N_IN);
      exp_addr = nn*(N_IN+1) + (exp_rd ? ph : N_IN);
      n_cmp++;
      if (w_rd !== exp_rd) begin
        n_err++; $display("FAIL addr_w_rd at E0+%0d: got %b, want %b", j, w_rd, exp_rd);
      end
      n_cmp++;
      if (w_addr !== AW'(exp_addr)) begin
        n_err++; $display("FAIL addr_w_addr at E0+%0d: got %0d, want %0d", j, w_addr, exp_addr);
      end
      @(negedge clk);
    end
    wait_idle(to);
    n_cmp++; if (to) begin n_err++; $display("FAIL wrap_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++;
    if (w_rd !== 1'b0 || w_addr !== AW'(NW - 1)) begin
      n_err++; $display("FAIL addr_hold_idle: got rd=%b addr=%0d, want rd=0 addr=%0d", w_rd, w_addr, NW - 1);
    end
  endtask

  task automatic test_ignore_start();
    bit to;
    for (int i = 0; i < N_IN; i++) act_arr[i] = 24'd32;
    pack_acts();
    fill_mem(24'd1, 24'd0);
    push_all(24'd15);
    n_out = 0;
    start_pass();
    while (cyc < e0 + 4) @(negedge clk);
    start = 1'b1;
    act_in = {N_IN{24'd100}};
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL ignore_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++; if (n_out != 32) begin n_err++; $display("FAIL ignore_count: got %0d outputs, want 32", n_out); end
    pack_acts();
  endtask

  task automatic test_back_to_back();
    bit to;
    int e_first, t;
    for (int i = 0; i < N_IN; i++) act_arr[i] = 24'd32;
    pack_acts();
    fill_mem(24'd1, 24'd0);
    push_all(24'd15);
    push_all(24'd15);
    n_out = 0;
    start_pass();
    e_first = e0;
    t = 0;
    while (done !== 1'b1 && t < 700) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (cyc - e_first != P*N_OUT) begin
      n_err++; $display("FAIL b2b_first_done: got E0+%0d, want E0+%0d", cyc - e_first, P*N_OUT);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = e_first + P*N_OUT + 1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_busy: got %b, want 1", busy); end
    wait_idle(to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL b2b_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++; if (n_out != 64) begin n_err++; $display("FAIL b2b_count: got %0d outputs, want 64", n_out); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int snap;
    for (int i = 0; i < N_IN; i++) act_arr[i] = W'($urandom_range(15));
    pack_acts();
    for (int n = 0; n < N_OUT; n++) begin
      for (int k = 0; k < N_IN; k++) mem[n*(N_IN+1)+k] = W'($urandom_range(16) - 8);
      mem[n*(N_IN+1)+N_IN] = W'($urandom_range(3000));
    end
    for (int n = 0; n < N_OUT; n++) sb.push_back('{idx: n, data: model(n)});
    n_out = 0;
    start_pass();
    do begin
      @(posedge clk);
      #1;
    end while (cyc < e0 + 40);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL mid_rst_busy: got %b, want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b, want 0", out_valid); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL mid_rst_done: got %b, want 0", done); end
    n_cmp++; if (w_rd !== 1'b0)      begin n_err++; $display("FAIL mid_rst_w_rd: got %b, want 0", w_rd); end
    n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL mid_rst_out_data: got %0d, want 0", out_data); end
    n_cmp++; if (n_out != 2)         begin n_err++; $display("FAIL mid_rst_partial: got %0d outputs, want 2", n_out); end
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap = n_out;
    repeat (40) @(negedge clk);
    n_cmp++; if (n_out != snap) begin n_err++; $display("FAIL mid_rst_quiet: got %0d extra outputs, want 0", n_out - snap); end
    for (int n = 0; n < N_OUT; n++) sb.push_back('{idx: n, data: model(n)});
    n_out = 0;
    start_pass();
    wait_idle(to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL mid_rst_rerun_timeout: got %0d pending, want 0", sb.size()); end
    n_cmp++; if (n_out != 32) begin n_err++; $display("FAIL mid_rst_rerun_count: got %0d outputs, want 32", n_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_thresholds();
    test_wrap_addr();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_mac_sequencer.md
# layer_mac_sequencer

Time-multiplexed layer engine for the fixed-point ECG classifier. It computes all output nodes of one dense layer on a single shared multiply-accumulate datapath, replacing per-node parallel instances. Weights and biases come from an external synchronous weight memory; results use the same ReLU/saturating 8-bit requantisation as the existing layer nodes. It sits between the previous layer's activation register bank and the next layer's input capture.

## Interface
- N_IN, 15: inputs per node (activations per pass).
- N_OUT, 32: output nodes sequenced per pass.
- W, 24: data width of activations, weights, products and accumulator.
- AW, 9: weight memory address width; must be ≥ clog2(N_OUT*(N_IN+1)).
- IW, 5: output index width; must be ≥ clog2(N_OUT).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- start  in  1  request a layer pass; sampled only while idle.
- act_in  in  N_IN*W  flattened activations, word k at bits [k*W+W-1:k*W]; captured on the accepted start edge.
- w_rd  out  1  weight memory read strobe.
- w_addr  out  AW  weight memory address = n*(N_IN+1)+k; k<N_IN is a weight, k=N_IN is the bias of node n.
- w_data  in  W  read data, valid exactly one cycle after w_rd/w_addr.
- busy  out  1  pass in progress.
- out_valid  out  1  one-cycle pulse, one per node.
- out_idx  out  IW  node index n of out_data.
- out_data  out  W  requantised node output, zero-extended from 8 bits.
- done  out  1  one-cycle pulse on the final node result.

## Operation
- States: IDLE, RUN. In IDLE, start=1 latches act_in into an internal N_IN×W bank, sets n=0 and k=0, and enters RUN. start during RUN is ignored.
- RUN issues one address per cycle: k=0..N_IN for node n (N_IN+1 cycles), then one drain cycle, then node n+1 begins. The period is P=N_IN+2 cycles per node.
- Accumulate on data return (one cycle after the issue): term = act[k]*w_data for k<N_IN, or term = w_data for k=N_IN. The product is truncated to W bits, two's complement.
- Accumulator: acc = (k==0 ? 0 : acc) + term, W-bit, wraps modulo 2^W, with no overflow detection.
- Requantisation on the drain cycle, evaluated in this order:
  - if acc[W-1]=1, out_data=0;
  - else if acc>8192, out_data=255;
  - else out_data=acc[12:5].
  - Consequence: acc=8192 yields 0. This is intentional for bit-exactness with the existing nodes.
- After node N_OUT-1's drain cycle, the block returns to IDLE.
- w_rd is high only on issue cycles. w_addr holds its last value when w_rd=0.
- Reset values: busy=0, out_valid=0, done=0, w_rd=0, w_addr=0, out_idx=0, out_data=0, acc=0, activation bank=0, state=IDLE.

## Timing
- E0 is the edge at which start is accepted.
- busy rises at E0 and falls at E0+P*N_OUT.
- Node n, address k is driven from edge E0+P*n+k (k=0..N_IN).
- Its w_data is consumed at edge E0+P*n+k+1.
- out_valid/out_idx=n/out_data are updated at edge E0+P*(n+1) and held one cycle. out_data and out_idx keep their values afterwards.
- done rises together with the last out_valid, at E0+P*N_OUT. With defaults (P=17) that is 544 cycles after E0.
- start may be re-asserted in the cycle done is high; it is then accepted at the next edge, so passes run back-to-back.
- Reset asserted mid-pass aborts immediately and asynchronously; no further out_valid or done is produced. Partial results are discarded. After reset deasserts, the first start runs a complete pass.
- w_data is ignored on all cycles other than the one following an issue.

## Test plan
- All act=32, all weights=1, all biases=0 -> 32 out_valid pulses, out_idx 0..31 in order, each out_data=15 (acc=480), done coincident with idx 31 at E0+544.
- All act=32, weights=-1, bias=0 -> acc=-480 -> every out_data=0; also set node 3 bias=+480 -> node 3 out_data=0, others 0.
- Weights=0, biases per node 8191 / 8192 / 8193 / 160 -> out_data 255 / 0 / 255 / 5.
- act[0]=0x800000, w0=2, other weights 0, bias 7 -> product wraps to 0, out_data=0 (acc=7); check w_addr sequence n*16+k and w_rd gaps on drain cycles.
- Pulse start at E0+5 and E0+100 during a pass -> ignored, exactly 32 outputs; assert start in the done cycle -> second pass starts with E0'=E0+545, outputs identical.
- Assert reset asynchronously mid-cycle at E0+40 -> busy, out_valid, done, w_rd and out_data go to 0 immediately, with no further pulses; the next start produces a full correct pass.
